// File: rtl/id_dual_issue_ctrl_pkg.sv
// Shared types and widths for the ID->EX dual-issue control block.
package issue_pkg;

    localparam int unsigned PAYLOAD_W  = 128;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 32;

    typedef enum logic {
        PAIR,
        SECOND
    } state_e;

    typedef enum logic [1:0] {
        ISSUE_NONE,
        ISSUE_L1,
        ISSUE_L2,
        ISSUE_DUAL
    } issue_e;

endpackage

// File: rtl/id_dual_issue_ctrl_if.sv
// ID bundle in, EX lanes and perf counters out, grouped for the issue controller.
interface id_dual_issue_ctrl_if import issue_pkg::*; ;

    logic                  id_valid_i;
    logic                  l1_valid_i;
    logic                  l2_valid_i;
    logic [PAYLOAD_W-1:0]  l1_payload_i;
    logic [PAYLOAD_W-1:0]  l2_payload_i;
    logic                  l1_rf_we_i;
    logic [REG_ADDR_W-1:0] l1_rf_waddr_i;
    logic                  l2_re1_i;
    logic                  l2_re2_i;
    logic [REG_ADDR_W-1:0] l2_raddr1_i;
    logic [REG_ADDR_W-1:0] l2_raddr2_i;
    logic                  l1_is_mem_i;
    logic                  l2_is_mem_i;
    logic                  l1_serial_i;
    logic                  l2_serial_i;
    logic                  l1_rd_ready_i;
    logic                  l2_rd_ready_i;
    logic                  ex_allowin_i;

    logic                  id_allowin_o;
    logic                  ex_l0_valid_o;
    logic                  ex_l1_valid_o;
    logic [PAYLOAD_W-1:0]  ex_l0_payload_o;
    logic [PAYLOAD_W-1:0]  ex_l1_payload_o;
    logic [CNT_W-1:0]      dual_cnt_o;
    logic [CNT_W-1:0]      single_cnt_o;

    modport master (
        output id_valid_i, l1_valid_i, l2_valid_i, l1_payload_i, l2_payload_i,
               l1_rf_we_i, l1_rf_waddr_i, l2_re1_i, l2_re2_i, l2_raddr1_i, l2_raddr2_i,
               l1_is_mem_i, l2_is_mem_i, l1_serial_i, l2_serial_i,
               l1_rd_ready_i, l2_rd_ready_i, ex_allowin_i,
        input  id_allowin_o, ex_l0_valid_o, ex_l1_valid_o,
               ex_l0_payload_o, ex_l1_payload_o, dual_cnt_o, single_cnt_o
    );

    modport slave (
        input  id_valid_i, l1_valid_i, l2_valid_i, l1_payload_i, l2_payload_i,
               l1_rf_we_i, l1_rf_waddr_i, l2_re1_i, l2_re2_i, l2_raddr1_i, l2_raddr2_i,
               l1_is_mem_i, l2_is_mem_i, l1_serial_i, l2_serial_i,
               l1_rd_ready_i, l2_rd_ready_i, ex_allowin_i,
        output id_allowin_o, ex_l0_valid_o, ex_l1_valid_o,
               ex_l0_payload_o, ex_l1_payload_o, dual_cnt_o, single_cnt_o
    );

endinterface

// File: rtl/id_dual_issue_ctrl_pair_check.sv
// Combinational pairability check for two adjacent decoded instructions.
module issue_pair_check
    import issue_pkg::*;
(
    input  logic                  l1_valid_i,
    input  logic                  l2_valid_i,
    input  logic                  l1_rf_we_i,
    input  logic [REG_ADDR_W-1:0] l1_rf_waddr_i,
    input  logic                  l2_re1_i,
    input  logic                  l2_re2_i,
    input  logic [REG_ADDR_W-1:0] l2_raddr1_i,
    input  logic [REG_ADDR_W-1:0] l2_raddr2_i,
    input  logic                  l1_is_mem_i,
    input  logic                  l2_is_mem_i,
    input  logic                  l1_serial_i,
    input  logic                  l2_serial_i,
    output logic                  pair_ok_c
);

    logic raw;

    // r0 is hardwired zero, so a write to it never creates a dependency.
    always_comb begin
        raw = l1_rf_we_i && (l1_rf_waddr_i != REG_ADDR_W'(0)) &&
              ((l2_re1_i && (l2_raddr1_i == l1_rf_waddr_i)) ||
               (l2_re2_i && (l2_raddr2_i == l1_rf_waddr_i)));

        pair_ok_c = l1_valid_i && l2_valid_i && !raw &&
                    !(l1_is_mem_i && l2_is_mem_i) &&
                    !l1_serial_i && !l2_serial_i;
    end

endmodule

// File: rtl/id_dual_issue_ctrl.sv
// Dual-issue decision FSM plus the ID->EX lane registers and issue counters.
module id_dual_issue_ctrl
    import issue_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    id_dual_issue_ctrl_if.slave  bus
);

    state_e               state_q, state_d;
    issue_e               issue;
    logic                 consumed;
    logic                 go;
    logic                 pair_ok;

    logic                 ex_l0_valid_q, ex_l0_valid_d;
    logic                 ex_l1_valid_q, ex_l1_valid_d;
    logic [PAYLOAD_W-1:0] ex_l0_payload_q, ex_l0_payload_d;
    logic [PAYLOAD_W-1:0] ex_l1_payload_q, ex_l1_payload_d;
    logic [CNT_W-1:0]     dual_cnt_q, dual_cnt_d;
    logic [CNT_W-1:0]     single_cnt_q, single_cnt_d;

    issue_pair_check u_pair_check (
        .l1_valid_i    (bus.l1_valid_i),
        .l2_valid_i    (bus.l2_valid_i),
        .l1_rf_we_i    (bus.l1_rf_we_i),
        .l1_rf_waddr_i (bus.l1_rf_waddr_i),
        .l2_re1_i      (bus.l2_re1_i),
        .l2_re2_i      (bus.l2_re2_i),
        .l2_raddr1_i   (bus.l2_raddr1_i),
        .l2_raddr2_i   (bus.l2_raddr2_i),
        .l1_is_mem_i   (bus.l1_is_mem_i),
        .l2_is_mem_i   (bus.l2_is_mem_i),
        .l1_serial_i   (bus.l1_serial_i),
        .l2_serial_i   (bus.l2_serial_i),
        .pair_ok_c     (pair_ok)
    );

    assign go = bus.id_valid_i && bus.ex_allowin_i && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PAIR;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue decision: bundle head is line1 in PAIR, line2 in SECOND.
    always_comb begin
        state_d  = state_q;
        issue    = ISSUE_NONE;
        consumed = 1'b0;
        case (state_q)
            PAIR: begin
                if (go && !bus.l1_valid_i) begin
                    consumed = 1'b1;
                end else if (go && bus.l1_rd_ready_i && pair_ok && bus.l2_rd_ready_i) begin
                    issue    = ISSUE_DUAL;
                    consumed = 1'b1;
                end else if (go && bus.l1_rd_ready_i) begin
                    issue = ISSUE_L1;
                    if (bus.l2_valid_i) begin
                        state_d = SECOND;
                    end else begin
                        consumed = 1'b1;
                    end
                end
            end
            SECOND: begin
                if (go && bus.l2_rd_ready_i) begin
                    issue    = ISSUE_L2;
                    consumed = 1'b1;
                    state_d  = PAIR;
                end
            end
            default: state_d = PAIR;
        endcase
        if (flush_i) begin
            state_d = PAIR;
        end
    end

    // EX lanes: lane0 always carries the oldest issued instruction.
    always_comb begin
        ex_l0_valid_d   = ex_l0_valid_q;
        ex_l1_valid_d   = ex_l1_valid_q;
        ex_l0_payload_d = ex_l0_payload_q;
        ex_l1_payload_d = ex_l1_payload_q;
        dual_cnt_d      = dual_cnt_q;
        single_cnt_d    = single_cnt_q;
        if (flush_i) begin
            ex_l0_valid_d = 1'b0;
            ex_l1_valid_d = 1'b0;
        end else if (bus.ex_allowin_i) begin
            ex_l0_valid_d   = (issue != ISSUE_NONE);
            ex_l1_valid_d   = (issue == ISSUE_DUAL);
            ex_l0_payload_d = (issue == ISSUE_L2) ? bus.l2_payload_i : bus.l1_payload_i;
            ex_l1_payload_d = bus.l2_payload_i;
        end
        // issue is only non-NONE under go, so flush and stall already suppress counting.
        if (issue == ISSUE_DUAL) begin
            dual_cnt_d = dual_cnt_q + CNT_W'(1);
        end
        if ((issue == ISSUE_L1) || (issue == ISSUE_L2)) begin
            single_cnt_d = single_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_l0_valid_q   <= 1'b0;
            ex_l1_valid_q   <= 1'b0;
            ex_l0_payload_q <= '0;
            ex_l1_payload_q <= '0;
            dual_cnt_q      <= '0;
            single_cnt_q    <= '0;
        end else begin
            ex_l0_valid_q   <= ex_l0_valid_d;
            ex_l1_valid_q   <= ex_l1_valid_d;
            ex_l0_payload_q <= ex_l0_payload_d;
            ex_l1_payload_q <= ex_l1_payload_d;
            dual_cnt_q      <= dual_cnt_d;
            single_cnt_q    <= single_cnt_d;
        end
    end

    assign bus.id_allowin_o    = !bus.id_valid_i || consumed || flush_i;
    assign bus.ex_l0_valid_o   = ex_l0_valid_q;
    assign bus.ex_l1_valid_o   = ex_l1_valid_q;
    assign bus.ex_l0_payload_o = ex_l0_payload_q;
    assign bus.ex_l1_payload_o = ex_l1_payload_q;
    assign bus.dual_cnt_o      = dual_cnt_q;
    assign bus.single_cnt_o    = single_cnt_q;

endmodule

// File: tb/tb_id_dual_issue_ctrl.sv
// Directed scoreboard bench for id_dual_issue_ctrl.
module tb_id_dual_issue_ctrl;
    import issue_pkg::*;

    logic clk;
    logic rst_n;
    logic flush_i;

    id_dual_issue_ctrl_if bus ();

    id_dual_issue_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string          tag;
        logic           l0v;
        logic [127:0]   l0p;
        logic           l1v;
        logic [127:0]   l1p;
        logic [31:0]    dual;
        logic [31:0]    single;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [127:0] pay(input int n);
        return {32'(n), 32'hA5A5_0000, 32'(n * 3), 32'h1234_5678};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.id_valid_i    = 1'b0;
        bus.l1_valid_i    = 1'b0;
        bus.l2_valid_i    = 1'b0;
        bus.l1_payload_i  = '0;
        bus.l2_payload_i  = '0;
        bus.l1_rf_we_i    = 1'b0;
        bus.l1_rf_waddr_i = '0;
        bus.l2_re1_i      = 1'b0;
        bus.l2_re2_i      = 1'b0;
        bus.l2_raddr1_i   = '0;
        bus.l2_raddr2_i   = '0;
        bus.l1_is_mem_i   = 1'b0;
        bus.l2_is_mem_i   = 1'b0;
        bus.l1_serial_i   = 1'b0;
        bus.l2_serial_i   = 1'b0;
        bus.l1_rd_ready_i = 1'b0;
        bus.l2_rd_ready_i = 1'b0;
    endtask

    task automatic bundle(input logic [4:0] wa, input logic [4:0] ra1, input logic [4:0] ra2,
                          input logic m1, input logic m2, input logic s1, input logic s2,
                          input logic l2v, input int p1, input int p2);
        bus.id_valid_i    = 1'b1;
        bus.l1_valid_i    = 1'b1;
        bus.l2_valid_i    = l2v;
        bus.l1_payload_i  = pay(p1);
        bus.l2_payload_i  = pay(p2);
        bus.l1_rf_we_i    = 1'b1;
        bus.l1_rf_waddr_i = wa;
        bus.l2_re1_i      = 1'b1;
        bus.l2_re2_i      = 1'b1;
        bus.l2_raddr1_i   = ra1;
        bus.l2_raddr2_i   = ra2;
        bus.l1_is_mem_i   = m1;
        bus.l2_is_mem_i   = m2;
        bus.l1_serial_i   = s1;
        bus.l2_serial_i   = s2;
        bus.l1_rd_ready_i = 1'b1;
        bus.l2_rd_ready_i = 1'b1;
    endtask

    // Check id_allowin before the edge, push expected EX state, compare after the edge.
    task automatic cycle(input string tag, input logic allow,
                         input logic l0v, input int l0p, input logic l1v, input int l1p,
                         input int dual, input int single);
        exp_t e;
        exp_t got;
        #1;
        chk({tag, ".id_allowin"}, 128'(bus.id_allowin_o), 128'(allow));
        e.tag = tag;  e.l0v = l0v;  e.l0p = pay(l0p);  e.l1v = l1v;  e.l1p = pay(l1p);
        e.dual = 32'(dual);  e.single = 32'(single);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({got.tag, ".l0_valid"}, 128'(bus.ex_l0_valid_o), 128'(got.l0v));
        chk({got.tag, ".l1_valid"}, 128'(bus.ex_l1_valid_o), 128'(got.l1v));
        if (got.l0v) chk({got.tag, ".l0_payload"}, bus.ex_l0_payload_o, got.l0p);
        if (got.l1v) chk({got.tag, ".l1_payload"}, bus.ex_l1_payload_o, got.l1p);
        chk({got.tag, ".dual_cnt"}, 128'(bus.dual_cnt_o), 128'(got.dual));
        chk({got.tag, ".single_cnt"}, 128'(bus.single_cnt_o), 128'(got.single));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".l0_valid"}, 128'(bus.ex_l0_valid_o), 128'(0));
        chk({tag, ".l1_valid"}, 128'(bus.ex_l1_valid_o), 128'(0));
        chk({tag, ".l0_payload"}, bus.ex_l0_payload_o, 128'(0));
        chk({tag, ".l1_payload"}, bus.ex_l1_payload_o, 128'(0));
        chk({tag, ".dual_cnt"}, 128'(bus.dual_cnt_o), 128'(0));
        chk({tag, ".single_cnt"}, 128'(bus.single_cnt_o), 128'(0));
    endtask

    initial begin
        rst_n   = 1'b0;
        flush_i = 1'b0;
        bus.ex_allowin_i = 1'b1;
        idle();
        #12;
        chk_zero("reset");
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Independent pair: add r4,r1,r2 / sub r5,r6,r7
        bundle(5'd4, 5'd6, 5'd7, 0, 0, 0, 0, 1, 1, 2);
        cycle("indep", 1, 1, 1, 1, 2, 1, 0);

        // RAW on r4 splits the bundle
        bundle(5'd4, 5'd4, 5'd7, 0, 0, 0, 0, 1, 3, 4);
        cycle("raw_c1", 0, 1, 3, 0, 0, 1, 1);
        cycle("raw_c2", 1, 1, 4, 0, 0, 1, 2);

        // Two memory ops split
        bundle(5'd8, 5'd9, 5'd10, 1, 1, 0, 0, 1, 5, 6);
        cycle("mem_c1", 0, 1, 5, 0, 0, 1, 3);
        cycle("mem_c2", 1, 1, 6, 0, 0, 1, 4);

        // Write to r0 is no dependency
        bundle(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 7, 8);
        cycle("r0_dual", 1, 1, 7, 1, 8, 2, 4);

        // l1 operands not ready for three cycles
        bundle(5'd11, 5'd12, 5'd13, 0, 0, 0, 0, 1, 9, 10);
        bus.l1_rd_ready_i = 1'b0;
        cycle("nrdy_1", 0, 0, 0, 0, 0, 2, 4);
        cycle("nrdy_2", 0, 0, 0, 0, 0, 2, 4);
        cycle("nrdy_3", 0, 0, 0, 0, 0, 2, 4);
        bus.l1_rd_ready_i = 1'b1;
        cycle("rdy", 1, 1, 9, 1, 10, 3, 4);

        // EX stall while in SECOND
        bundle(5'd4, 5'd1, 5'd4, 0, 0, 0, 0, 1, 11, 12);
        cycle("stall_c1", 0, 1, 11, 0, 0, 3, 5);
        bus.ex_allowin_i = 1'b0;
        cycle("stall_h1", 0, 1, 11, 0, 0, 3, 5);
        cycle("stall_h2", 0, 1, 11, 0, 0, 3, 5);
        bus.ex_allowin_i = 1'b1;
        cycle("stall_go", 1, 1, 12, 0, 0, 3, 6);

        // Flush in SECOND returns to PAIR: the same bundle re-issues line1
        bundle(5'd4, 5'd4, 5'd4, 0, 0, 0, 0, 1, 13, 14);
        cycle("fl_c1", 0, 1, 13, 0, 0, 3, 7);
        flush_i = 1'b1;
        cycle("fl_flush", 1, 0, 0, 0, 0, 3, 7);
        flush_i = 1'b0;
        cycle("fl_re_l1", 0, 1, 13, 0, 0, 3, 8);
        cycle("fl_re_l2", 1, 1, 14, 0, 0, 3, 9);

        // Serial line1 issues alone
        bundle(5'd20, 5'd21, 5'd22, 0, 0, 1, 0, 1, 15, 16);
        cycle("ser1_c1", 0, 1, 15, 0, 0, 3, 10);
        cycle("ser1_c2", 1, 1, 16, 0, 0, 3, 11);

        // Bubble: l1 invalid consumes with nothing issued
        bundle(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 90, 91);
        bus.l1_valid_i = 1'b0;
        cycle("bubble", 1, 0, 0, 0, 0, 3, 11);

        // Lone line1
        bundle(5'd2, 5'd2, 5'd2, 0, 0, 0, 0, 0, 17, 99);
        cycle("l1_only", 1, 1, 17, 0, 0, 3, 11 + 1);

        // Flush together with a dual-issuable bundle: flush wins, no count
        bundle(5'd3, 5'd5, 5'd6, 0, 0, 0, 1, 1, 18, 19);
        bus.l2_serial_i = 1'b0;
        flush_i = 1'b1;
        cycle("fl_dual", 1, 0, 0, 0, 0, 3, 12);
        flush_i = 1'b0;

        // Serial line2
        bus.l2_serial_i = 1'b1;
        cycle("ser2_c1", 0, 1, 18, 0, 0, 3, 13);
        cycle("ser2_c2", 1, 1, 19, 0, 0, 3, 14);

        idle();
        cycle("idle", 1, 0, 0, 0, 0, 3, 14);

        // Split, then l2 not ready in SECOND, then async reset drops l2
        bundle(5'd7, 5'd7, 5'd1, 0, 0, 0, 0, 1, 20, 21);
        cycle("rst_c1", 0, 1, 20, 0, 0, 3, 15);
        bus.l2_rd_ready_i = 1'b0;
        cycle("rst_l2wait", 0, 0, 0, 0, 0, 3, 15);
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        #2 rst_n = 1'b1;
        bus.l2_rd_ready_i = 1'b1;
        cycle("post_rst_l1", 0, 1, 20, 0, 0, 0, 1);
        cycle("post_rst_l2", 1, 1, 21, 0, 0, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
